// File: rtl/rv_addr_line_en_target_regs.sv
`default_nettype none
// ============================================================================
// Module   : rv_addr_line_en_target_regs
// Brief    : Valid/ready register target with programmable wait states
//            (ID, WAIT, ACC_CNT and SCRATCH registers).
// Revision : 1.0 - initial release
// ============================================================================
module rv_addr_line_en_target_regs #(
  parameter int          ADR_WIDTH = 4,
  parameter int          DAT_WIDTH = 32,
  parameter logic [31:0] ID_VALUE  = 32'hF00D_0001
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ADR_WIDTH-1:0] adr,
  input  logic [DAT_WIDTH-1:0] dat_w,
  input  logic                 we,
  input  logic                 valid,
  output logic [DAT_WIDTH-1:0] dat_r,
  output logic                 ready
);

  localparam int                 c_depth    = 1 << ADR_WIDTH;
  localparam logic [ADR_WIDTH-1:0] c_adr_id   = ADR_WIDTH'(0);
  localparam logic [ADR_WIDTH-1:0] c_adr_wait = ADR_WIDTH'(1);
  localparam logic [ADR_WIDTH-1:0] c_adr_acc  = ADR_WIDTH'(2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ADR_WIDTH-1:0] r_adr;
  logic                 r_we;
  logic [DAT_WIDTH-1:0] r_dat;
  logic [3:0]           r_cnt;
  logic [3:0]           r_wait;
  logic [DAT_WIDTH-1:0] r_acc;
  logic [DAT_WIDTH-1:0] r_scratch [c_depth];
  logic [DAT_WIDTH-1:0] w_rdata;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (valid) w_state_nxt = (r_wait != 4'd0) ? S_WAIT : S_RESP;
      S_WAIT: if (r_cnt == 4'd1) w_state_nxt = S_RESP;
      S_RESP: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request capture, wait countdown, and register commit at the end of RESP.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_adr  <= '0;
      r_we   <= 1'b0;
      r_dat  <= '0;
      r_cnt  <= 4'd0;
      r_wait <= 4'd0;
      r_acc  <= '0;
      for (int i = 0; i < c_depth; i++) r_scratch[i] <= '0;
    end else begin
      if (r_state == S_IDLE && valid) begin
        r_adr <= adr;
        r_we  <= we;
        r_dat <= dat_w;
        r_cnt <= r_wait;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end

      if (r_state == S_RESP) begin
        if (r_we && r_adr == c_adr_acc) r_acc <= '0;
        else                            r_acc <= r_acc + DAT_WIDTH'(1);
        if (r_we) begin
          if (r_adr == c_adr_wait) begin
            r_wait <= r_dat[3:0];
          end else if (r_adr != c_adr_id && r_adr != c_adr_acc) begin
            r_scratch[r_adr] <= r_dat;
          end
        end
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (r_adr == c_adr_id)        w_rdata[31:0] = ID_VALUE;
    else if (r_adr == c_adr_wait) w_rdata[3:0]  = r_wait;
    else if (r_adr == c_adr_acc)  w_rdata       = r_acc;
    else                          w_rdata       = r_scratch[r_adr];
  end

  always_comb begin
    ready = (r_state == S_RESP);
    dat_r = (ready && !r_we) ? w_rdata : '0;
  end

endmodule
`default_nettype wire
